// File: rtl/cnn_infer_ctrl.sv
// rtl/cnn_infer_ctrl.sv - Button-driven CNN inference front end with timeout, auto-sweep and result history.
module cnn_infer_ctrl #(
    parameter int DB_CNT  = 100000,
    parameter int N_BTN   = 2,
    parameter int IMG_W   = 4,
    parameter int N_IMG   = 16,
    parameter int ALPHA_W = 8,
    parameter int TO_CYC  = 1000000,
    parameter int HIST_AW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   i_btn,
    input  logic [IMG_W-1:0]   sw,
    output logic               o_start,
    output logic [IMG_W-1:0]   o_img_sel,
    input  logic               i_core_valid,
    input  logic [ALPHA_W-1:0] i_core_alpha,
    output logic [ALPHA_W-1:0] alpha,
    output logic               out_valid,
    output logic               busy,
    output logic               err,
    output logic [2:0]         led,
    input  logic [HIST_AW-1:0] hist_rd_idx,
    output logic [ALPHA_W-1:0] hist_rd_data,
    output logic [HIST_AW:0]   hist_cnt
);

    localparam int HD   = 1 << HIST_AW;
    localparam int DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int TM_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DB_CNT - 1);
    localparam logic [TM_W-1:0]    TM_LAST   = TM_W'(TO_CYC - 1);
    localparam logic [IMG_W-1:0]   IMG_LAST  = IMG_W'(N_IMG - 1);
    localparam logic [HIST_AW:0]   HIST_FULL = (HIST_AW + 1)'(HD);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERR} state_t;

    logic [N_BTN-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_BTN-1:0]   db_q, db_d, btn_p_q, btn_p_d;
    logic [DB_W-1:0]    db_cnt_q [N_BTN];
    logic [DB_W-1:0]    db_cnt_d [N_BTN];

    state_t             state_q, state_d;
    logic               auto_q, auto_d;
    logic [IMG_W-1:0]   img_q, img_d;
    logic [TM_W-1:0]    timer_q, timer_d;
    logic [ALPHA_W-1:0] alpha_q, alpha_d;
    logic               out_valid_q, out_valid_d;
    logic               o_start_q, o_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               hist_we;

    logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
    logic [HIST_AW:0]   hist_cnt_q, hist_cnt_d;
    logic [ALPHA_W-1:0] hist_rd_q, hist_rd_d;
    logic [ALPHA_W-1:0] hist_mem_q [HD];
    logic [ALPHA_W-1:0] hist_mem_d [HD];

    logic start_p, mode_p;

    assign start_p = btn_p_q[0];
    generate
        if (N_BTN > 1) begin : g_mode
            assign mode_p = btn_p_q[1];
        end else begin : g_no_mode
            assign mode_p = 1'b0;
        end
    endgenerate

    // The counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        btn_p_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]    = ~db_q[i];
                    btn_p_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        auto_d      = auto_q;
        img_d       = img_q;
        timer_d     = timer_q;
        alpha_d     = alpha_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        hist_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    img_d   = auto_q ? '0 : sw;
                    state_d = S_START;
                end else if (mode_p) begin
                    auto_d = ~auto_q;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (i_core_valid) begin
                    alpha_d     = i_core_alpha;
                    out_valid_d = 1'b1;
                    hist_we     = 1'b1;
                    state_d     = S_DONE;
                end else if (timer_q == TM_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                if (auto_q && img_q != IMG_LAST) begin
                    img_d   = img_q + 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (start_p) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        o_start_d = (state_d == S_START);
        busy_d    = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_DONE);
    end

    // Index 0 is the newest entry, i.e. one behind the write pointer.
    assign rd_addr = wr_ptr_q - HIST_AW'(1) - hist_rd_idx;

    always_comb begin
        hist_mem_d = hist_mem_q;
        wr_ptr_d   = wr_ptr_q;
        hist_cnt_d = hist_cnt_q;
        if (hist_we) begin
            hist_mem_d[wr_ptr_q] = i_core_alpha;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            if (hist_cnt_q != HIST_FULL) begin
                hist_cnt_d = hist_cnt_q + 1'b1;
            end
        end
        hist_rd_d = ({1'b0, hist_rd_idx} < hist_cnt_q) ? hist_mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            btn_p_q     <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q     <= S_IDLE;
            auto_q      <= 1'b0;
            img_q       <= '0;
            timer_q     <= '0;
            alpha_q     <= '0;
            out_valid_q <= 1'b0;
            o_start_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            hist_cnt_q  <= '0;
            hist_rd_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            btn_p_q     <= btn_p_d;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q     <= state_d;
            auto_q      <= auto_d;
            img_q       <= img_d;
            timer_q     <= timer_d;
            alpha_q     <= alpha_d;
            out_valid_q <= out_valid_d;
            o_start_q   <= o_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            hist_cnt_q  <= hist_cnt_d;
            hist_rd_q   <= hist_rd_d;
        end
    end

    // Entries beyond hist_cnt are masked on read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        hist_mem_q <= hist_mem_d;
    end

    assign o_start      = o_start_q;
    assign o_img_sel    = img_q;
    assign alpha        = alpha_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign led          = {err_q, auto_q, busy_q};
    assign hist_rd_data = hist_rd_q;
    assign hist_cnt     = hist_cnt_q;

endmodule

// File: tb/tb_cnn_infer_ctrl.sv
// tb/tb_cnn_infer_ctrl.sv - Directed scoreboard bench for cnn_infer_ctrl.
module tb_cnn_infer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] i_btn;
    logic [3:0] sw;
    logic       o_start;
    logic [3:0] o_img_sel;
    logic       i_core_valid;
    logic [7:0] i_core_alpha;
    logic [7:0] alpha;
    logic       out_valid;
    logic       busy;
    logic       err;
    logic [2:0] led;
    logic [1:0] hist_rd_idx;
    logic [7:0] hist_rd_data;
    logic [2:0] hist_cnt;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_ov = 0;

    logic [3:0] exp_img [$];
    logic [7:0] exp_alpha [$];
    logic [7:0] resp_q [$];

    logic       core_en;
    int         rcnt = 0;
    logic       cv_r = 1'b0;
    logic [7:0] cd_r = 8'h00;
    logic       man_v;
    logic [7:0] man_d;
    logic       ov_prev = 1'b0;

    assign i_core_valid = cv_r | man_v;
    assign i_core_alpha = cd_r | man_d;

    cnn_infer_ctrl #(
        .DB_CNT(4), .N_BTN(2), .IMG_W(4), .N_IMG(4),
        .ALPHA_W(8), .TO_CYC(20), .HIST_AW(2)
    ) dut (
        .clk(clk), .reset(reset), .i_btn(i_btn), .sw(sw),
        .o_start(o_start), .o_img_sel(o_img_sel),
        .i_core_valid(i_core_valid), .i_core_alpha(i_core_alpha),
        .alpha(alpha), .out_valid(out_valid), .busy(busy), .err(err), .led(led),
        .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data), .hist_cnt(hist_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!o_start && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, 32'(o_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic press(input int b);
        i_btn[b] = 1'b1;
        tick(10);
        i_btn[b] = 1'b0;
        tick(10);
    endtask

    task automatic rd(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        hist_rd_idx = idx;
        tick(1);
        check(tag, 32'(hist_rd_data), 32'(exp));
    endtask

    // Core model: answers each o_start after a fixed delay with the next queued result.
    always @(negedge clk) begin
        cv_r = 1'b0;
        cd_r = 8'h00;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0 && resp_q.size() > 0) begin
                cv_r = 1'b1;
                cd_r = resp_q.pop_front();
            end
        end
        if (o_start && core_en) rcnt = 3;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (o_start) begin
                n_start++;
                check("start_expected", 32'(exp_img.size() > 0), 32'd1);
                if (exp_img.size() > 0) check("img_sel", 32'(o_img_sel), 32'(exp_img.pop_front()));
            end
            if (out_valid) begin
                n_ov++;
                check("ov_pulse_width", 32'(ov_prev), 32'd0);
                check("valid_expected", 32'(exp_alpha.size() > 0), 32'd1);
                if (exp_alpha.size() > 0) check("alpha", 32'(alpha), 32'(exp_alpha.pop_front()));
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int nst;
        int nov;
        int lat;
        reset = 1'b1; i_btn = 2'b00; sw = 4'd0; hist_rd_idx = 2'd0;
        core_en = 1'b1; man_v = 1'b0; man_d = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_o_start", 32'(o_start), 32'd0);
        check("rst_img_sel", 32'(o_img_sel), 32'd0);
        check("rst_alpha", 32'(alpha), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_hist_cnt", 32'(hist_cnt), 32'd0);
        check("rst_hist_rd", 32'(hist_rd_data), 32'd0);

        // Bounce then settle; manual run on image 5.
        sw = 4'd5;
        exp_img.push_back(4'd5); resp_q.push_back(8'h41); exp_alpha.push_back(8'h41);
        nst = n_start; nov = n_ov;
        for (int i = 0; i < 4; i++) begin
            i_btn[0] = (i % 2 == 0);
            tick(2);
        end
        check("bounce_no_start", 32'(n_start - nst), 32'd0);
        i_btn[0] = 1'b1;
        lat = 0;
        while (!o_start && lat < 20) begin
            tick(1);
            lat++;
        end
        check("db_latency", 32'(lat), 32'd7);
        tick(10);
        check("one_start", 32'(n_start - nst), 32'd1);
        wait_idle("m_idle", 20);
        i_btn[0] = 1'b0;
        tick(8);
        check("m_img_sel", 32'(o_img_sel), 32'd5);
        check("m_alpha", 32'(alpha), 32'h41);
        check("m_ov_count", 32'(n_ov - nov), 32'd1);
        check("m_hist_cnt", 32'(hist_cnt), 32'd1);
        rd(2'd0, 8'h41, "m_hist0");
        rd(2'd1, 8'h00, "m_hist1_empty");

        // Auto sweep.
        press(1);
        check("auto_on", 32'(led[1]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            exp_img.push_back(4'(i));
            resp_q.push_back(8'h10 + 8'(i));
            exp_alpha.push_back(8'h10 + 8'(i));
        end
        nst = n_start; nov = n_ov;
        i_btn[0] = 1'b1;
        wait_start("a_start");
        wait_idle("a_idle", 80);
        i_btn[0] = 1'b0;
        tick(8);
        check("a_starts", 32'(n_start - nst), 32'd4);
        check("a_ovs", 32'(n_ov - nov), 32'd4);
        check("a_img_last", 32'(o_img_sel), 32'd3);
        check("a_hist_cnt", 32'(hist_cnt), 32'd4);
        for (int i = 0; i < 4; i++) rd(2'(i), 8'h13 - 8'(i), "a_hist");
        press(1);
        check("auto_off", 32'(led[1]), 32'd0);

        // Timeout.
        core_en = 1'b0;
        sw = 4'd7;
        exp_img.push_back(4'd7);
        i_btn[0] = 1'b1;
        wait_start("t_start");
        i_btn[0] = 1'b0;
        tick(20);
        check("t_err_early", 32'(err), 32'd0);
        tick(1);
        check("t_err", 32'(err), 32'd1);
        check("t_led", 32'(led), 32'b100);
        man_d = 8'h77; man_v = 1'b1;
        tick(1);
        man_v = 1'b0; man_d = 8'h00;
        tick(2);
        check("t_late_alpha", 32'(alpha), 32'h13);
        nst = n_start;
        press(0);
        check("t_err_clr", 32'(err), 32'd0);
        check("t_no_start", 32'(n_start - nst), 32'd0);
        check("t_busy", 32'(busy), 32'd0);
        core_en = 1'b1;

        // History wrap.
        for (int v = 1; v <= 5; v++) begin
            sw = 4'(v);
            exp_img.push_back(4'(v)); resp_q.push_back(8'(v)); exp_alpha.push_back(8'(v));
            i_btn[0] = 1'b1;
            wait_start("h_start");
            i_btn[0] = 1'b0;
            wait_idle("h_idle", 20);
            tick(8);
        end
        check("h_cnt_sat", 32'(hist_cnt), 32'd4);
        rd(2'd0, 8'h05, "h_idx0");
        rd(2'd1, 8'h04, "h_idx1");
        rd(2'd3, 8'h02, "h_idx3");

        // Reset mid-WAIT, then a stale valid.
        core_en = 1'b0;
        sw = 4'd9;
        exp_img.push_back(4'd9);
        i_btn[0] = 1'b1;
        wait_start("r_start");
        i_btn[0] = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("r_busy", 32'(busy), 32'd0);
        check("r_img_sel", 32'(o_img_sel), 32'd0);
        check("r_alpha", 32'(alpha), 32'd0);
        check("r_led", 32'(led), 32'd0);
        check("r_hist_cnt", 32'(hist_cnt), 32'd0);
        tick(1);
        man_d = 8'h99; man_v = 1'b1;
        tick(1);
        man_v = 1'b0; man_d = 8'h00;
        tick(2);
        check("r_alpha_kept", 32'(alpha), 32'd0);
        check("r_busy_after", 32'(busy), 32'd0);

        // Start and mode in the same cycle: start wins.
        core_en = 1'b1;
        sw = 4'd3;
        exp_img.push_back(4'd3); resp_q.push_back(8'h5a); exp_alpha.push_back(8'h5a);
        i_btn = 2'b11;
        wait_start("s_start");
        i_btn = 2'b00;
        wait_idle("s_idle", 20);
        tick(8);
        check("s_auto_kept", 32'(led[1]), 32'd0);
        check("s_alpha", 32'(alpha), 32'h5a);
        check("s_hist_cnt", 32'(hist_cnt), 32'd1);

        check("sb_img_drained", 32'(exp_img.size()), 32'd0);
        check("sb_alpha_drained", 32'(exp_alpha.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
